// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register so consecutive bytes leave gap-free.
// Build option: define UART_TX_PARITY_EN to insert a parity bit (sense set by PARITY_ODD).
module uart_tx #(
    parameter int unsigned CLK_DIV    = 434,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] uart_send_data,
    input  logic       uart_send,
    output logic       uart_send_busy,
    output logic       uart_txd,
    output logic       uart_tx_active
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    // Complete shifter state in one struct so checkers can bind to a single signal.
    typedef struct packed {
        state_t           state;
        logic [CNT_W-1:0] baud_cnt;
        logic [2:0]       bit_idx;
        logic [7:0]       shift_reg;
    } shifter_t;

    shifter_t   sh;
    logic [7:0] hold_data;
    logic       hold_valid;
    logic       bit_end;
    logic       accept;

    // Handshake: uart_send is valid, !uart_send_busy is ready; a byte transfers on a
    // posedge where both are high. A request while busy is dropped, not stalled.
    assign accept         = uart_send && !hold_valid;
    assign bit_end        = (sh.baud_cnt == CNT_LAST);
    assign uart_send_busy = hold_valid;

`ifndef UART_TX_PARITY_EN
    logic unused_parity_cfg;
    assign unused_parity_cfg = PARITY_ODD;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            sh.state       <= IDLE;
            sh.baud_cnt    <= '0;
            sh.bit_idx     <= '0;
            sh.shift_reg   <= '0;
            hold_data      <= '0;
            hold_valid     <= 1'b0;
            uart_txd       <= 1'b1;
            uart_tx_active <= 1'b0;
        end else begin
            if (accept) begin
                hold_data  <= uart_send_data;
                hold_valid <= 1'b1;
            end

            if (sh.state != IDLE) begin
                sh.baud_cnt <= bit_end ? '0 : sh.baud_cnt + 1'b1;
            end

            case (sh.state)
                IDLE: begin
                    uart_txd <= 1'b1;
                    if (hold_valid) begin
                        sh.shift_reg   <= hold_data;
                        hold_valid     <= 1'b0;
                        sh.state       <= START;
                        sh.baud_cnt    <= '0;
                        uart_txd       <= 1'b0;
                        uart_tx_active <= 1'b1;
                    end
                end

                START: begin
                    if (bit_end) begin
                        sh.state   <= DATA;
                        sh.bit_idx <= 3'd0;
                        uart_txd   <= sh.shift_reg[0];
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        if (sh.bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            sh.state <= PARITY;
                            uart_txd <= (^sh.shift_reg) ^ PARITY_ODD;
`else
                            sh.state <= STOP;
                            uart_txd <= 1'b1;
`endif
                        end else begin
                            sh.bit_idx <= sh.bit_idx + 3'd1;
                            uart_txd   <= sh.shift_reg[sh.bit_idx + 3'd1];
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        sh.state <= STOP;
                        uart_txd <= 1'b1;
                    end
                end
`endif

                STOP: begin
                    if (bit_end) begin
                        // A byte already waiting goes straight into the next start bit.
                        if (hold_valid) begin
                            sh.shift_reg   <= hold_data;
                            hold_valid     <= 1'b0;
                            sh.state       <= START;
                            sh.baud_cnt    <= '0;
                            uart_txd       <= 1'b0;
                            uart_tx_active <= 1'b1;
                        end else begin
                            sh.state       <= IDLE;
                            uart_txd       <= 1'b1;
                            uart_tx_active <= 1'b0;
                        end
                    end
                end

                default: begin
                    sh.state       <= IDLE;
                    sh.baud_cnt    <= '0;
                    uart_txd       <= 1'b1;
                    uart_tx_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at CLK_DIV=4; line levels are predicted per cycle from frame rules.
module tb_uart_tx;

    localparam int DIV     = 4;
    localparam bit PAR_ODD = 1'b0;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = DIV * NBITS;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] uart_send_data = 8'h00;
    logic       uart_send = 1'b0;
    logic       uart_send_busy;
    logic       uart_txd;
    logic       uart_tx_active;

    int checks = 0;
    int errors = 0;
    logic [0:0] exp_q[$];

    uart_tx #(.CLK_DIV(DIV), .PARITY_ODD(PAR_ODD)) dut (
        .clk            (clk),
        .rst            (rst),
        .uart_send_data (uart_send_data),
        .uart_send      (uart_send),
        .uart_send_busy (uart_send_busy),
        .uart_txd       (uart_txd),
        .uart_tx_active (uart_tx_active)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: a frame is start(0), 8 data bits LSB first, optional parity, stop(1), each DIV cycles.
    task automatic model_frame(input logic [7:0] b);
        logic lvl;
        for (int k = 0; k < NBITS; k++) begin
            if (k == 0)
                lvl = 1'b0;
            else if (k <= 8)
                lvl = b[k-1];
            else if ((NBITS == 11) && (k == 9))
                lvl = (($countones(b) % 2) == 1) ^ PAR_ODD;
            else
                lvl = 1'b1;
            repeat (DIV) exp_q.push_back(lvl);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        uart_send = 1'b0;
        for (int i = 0; i < 23; i++) begin
            if (i == 3) rst = 1'b1;
            tick();
            checks++;
            if (uart_txd !== 1'b1 || uart_send_busy !== 1'b0 || uart_tx_active !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: txd=%b busy=%b active=%b, required 1 0 0",
                         i, uart_txd, uart_send_busy, uart_tx_active);
            end
        end
    endtask

    task automatic test_single(input logic [7:0] b);
        exp_q.delete();
        model_frame(b);
        uart_send_data = b;
        uart_send = 1'b1;
        tick();
        uart_send = 1'b0;
        checks++;
        if (uart_send_busy !== 1'b1 || uart_txd !== 1'b1) begin
            errors++;
            $display("FAIL single_accept %h: busy=%b txd=%b, required busy=1 txd=1", b, uart_send_busy, uart_txd);
        end
        tick();
        for (int i = 0; i < FRAME; i++) begin
            uart_send_data = 8'($urandom);
            checks++;
            if (uart_txd !== exp_q[i] || uart_tx_active !== 1'b1 || uart_send_busy !== 1'b0) begin
                errors++;
                $display("FAIL single_line %h cycle %0d: txd=%b active=%b busy=%b, required txd=%b active=1 busy=0",
                         b, i, uart_txd, uart_tx_active, uart_send_busy, exp_q[i]);
            end
            tick();
        end
        checks++;
        if (uart_txd !== 1'b1 || uart_tx_active !== 1'b0) begin
            errors++;
            $display("FAIL single_end %h: txd=%b active=%b, required txd=1 active=0", b, uart_txd, uart_tx_active);
        end
    endtask

    task automatic test_back_to_back(input logic [7:0] b0, input logic [7:0] b1);
        logic exp_busy;
        exp_q.delete();
        model_frame(b0);
        model_frame(b1);
        uart_send_data = b0;
        uart_send = 1'b1;
        tick();
        uart_send = 1'b0;
        tick();
        for (int i = 0; i < 2 * FRAME; i++) begin
            // Second byte waits in the holding register until the first frame's last stop cycle.
            exp_busy = (i >= 1) && (i < FRAME);
            checks++;
            if (uart_txd !== exp_q[i] || uart_send_busy !== exp_busy || uart_tx_active !== 1'b1) begin
                errors++;
                $display("FAIL b2b_line %h/%h cycle %0d: txd=%b busy=%b active=%b, required txd=%b busy=%b active=1",
                         b0, b1, i, uart_txd, uart_send_busy, uart_tx_active, exp_q[i], exp_busy);
            end
            if (i == 0) begin
                uart_send_data = b1;
                uart_send = 1'b1;
            end
            if (i == 1) uart_send = 1'b0;
            tick();
        end
        checks++;
        if (uart_txd !== 1'b1 || uart_tx_active !== 1'b0 || uart_send_busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: txd=%b active=%b busy=%b, required 1 0 0", uart_txd, uart_tx_active, uart_send_busy);
        end
    endtask

    task automatic test_drop();
        logic [7:0] bytes[3];
        logic [0:0] cap[$];
        int idx;
        bytes[0] = 8'h11;
        bytes[1] = 8'h22;
        bytes[2] = 8'h33;
        idx = 0;
        exp_q.delete();
        exp_q.push_back(1'b1);
        for (int j = 0; j < 3; j++) model_frame(bytes[j]);
        repeat (10) exp_q.push_back(1'b1);
        for (int t = 0; t < exp_q.size(); t++) begin
            if (uart_send_busy === 1'b0 && idx < 3) begin
                uart_send_data = bytes[idx];
                uart_send = 1'b1;
                idx++;
            end else if (uart_send_busy === 1'b1) begin
                uart_send_data = 8'h44;
                uart_send = 1'b1;
            end else begin
                uart_send = 1'b0;
            end
            tick();
            cap.push_back(uart_txd);
        end
        uart_send = 1'b0;
        checks++;
        if (idx != 3) begin
            errors++;
            $display("FAIL drop_sent: offered %0d bytes, required 3", idx);
        end
        for (int t = 0; t < exp_q.size(); t++) begin
            checks++;
            if (cap[t] !== exp_q[t]) begin
                errors++;
                $display("FAIL drop_line cycle %0d: txd=%b, required %b", t, cap[t], exp_q[t]);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_q.delete();
        model_frame(8'h00);
        uart_send_data = 8'h00;
        uart_send = 1'b1;
        tick();
        uart_send = 1'b0;
        tick();
        for (int i = 0; i < 17; i++) begin
            if (i == 0) begin
                uart_send_data = 8'($urandom);
                uart_send = 1'b1;
            end
            if (i == 1) uart_send = 1'b0;
            tick();
        end
        // Now inside data bit 3 of the first frame with the second byte pending.
        checks++;
        if (uart_txd !== exp_q[17] || uart_send_busy !== 1'b1 || uart_tx_active !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: txd=%b busy=%b active=%b, required txd=%b busy=1 active=1",
                     uart_txd, uart_send_busy, uart_tx_active, exp_q[17]);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (uart_txd !== 1'b1 || uart_send_busy !== 1'b0 || uart_tx_active !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_edge: txd=%b busy=%b active=%b, required 1 0 0",
                     uart_txd, uart_send_busy, uart_tx_active);
        end
        rst = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            checks++;
            if (uart_txd !== 1'b1 || uart_send_busy !== 1'b0 || uart_tx_active !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_after cycle %0d: txd=%b busy=%b active=%b, required 1 0 0",
                         i, uart_txd, uart_send_busy, uart_tx_active);
            end
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] b;
        logic       exp_lvl;
        int         slot;
        b = 8'h07;
        uart_send_data = b;
        uart_send = 1'b1;
        tick();
        uart_send = 1'b0;
        tick();
        for (int i = 0; i < 11 * DIV; i++) begin
            slot = i / DIV;
            if (slot == 0)
                exp_lvl = 1'b0;
            else if (slot <= 8)
                exp_lvl = b[slot-1];
            else if (slot == 9)
                exp_lvl = 1'b1 ^ PAR_ODD;
            else
                exp_lvl = 1'b1;
            checks++;
            if (uart_txd !== exp_lvl || uart_tx_active !== 1'b1) begin
                errors++;
                $display("FAIL parity_line cycle %0d: txd=%b active=%b, required txd=%b active=1",
                         i, uart_txd, uart_tx_active, exp_lvl);
            end
            tick();
        end
        checks++;
        if (uart_tx_active !== 1'b0 || uart_txd !== 1'b1) begin
            errors++;
            $display("FAIL parity_end: active=%b txd=%b, required active=0 txd=1", uart_tx_active, uart_txd);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single(8'hA5);
        for (int n = 0; n < 4; n++) test_single(8'($urandom));
        test_back_to_back(8'h00, 8'hFF);
        test_back_to_back(8'($urandom), 8'($urandom));
        test_drop();
        test_reset_mid();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter at the far end of the csrfile UART send channel.
- Consumes the `uart_send` / `uart_send_data` byte requests issued by csrfile.
- Returns `uart_send_busy` and drives the 8N1 serial line `uart_txd`.
- Holds one byte while another is being shifted out, so back-to-back bytes leave with no idle gap between frames.

Parameters:
- CLK_DIV, 434, clock cycles per bit (50 MHz / 115200); legal range 2..65535.
- PARITY_ODD, 0, parity sense when `UART_TX_PARITY_EN` is defined (0 = even, 1 = odd); ignored otherwise.

Ports:
- clk  input  1  core clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-low; sampled on posedge clk.
- uart_send_data  input  8  byte to transmit; valid when uart_send=1.
- uart_send  input  1  request; accepted on a posedge where uart_send=1 and uart_send_busy=0.
- uart_send_busy  output  1  holding register full; new requests are ignored while high.
- uart_txd  output  1  serial line; idle high.
- uart_tx_active  output  1  a frame is on the line (shifter not IDLE).

Behaviour:
- Reset (rst=0 at a posedge) takes effect at that edge:
  - uart_txd=1, uart_send_busy=0, uart_tx_active=0.
  - Holding register emptied, FSM to IDLE, baud counter and bit index cleared.
  - Applies mid-frame too: the line returns high immediately and the frame is truncated.
- All outputs are registered.
- Holding register (hold_data[7:0], hold_valid); uart_send_busy = hold_valid.
  - Accept at edge N: hold_data <= uart_send_data, hold_valid <= 1.
  - A request while busy is dropped with no side effect; the sender must retry.
- Shifter FSM states: IDLE, START, DATA, STOP (plus PARITY under the option).
  - IDLE: uart_txd=1. If hold_valid at an edge: shift_reg <= hold_data, hold_valid <= 0, go to START, baud_cnt <= 0.
  - Consequence: with the shifter idle, busy is high for exactly one cycle (N+1), and uart_txd falls to 0 after edge N+1.
  - START: uart_txd=0 for CLK_DIV cycles, then DATA with bit_idx=0.
  - DATA: uart_txd=shift_reg[bit_idx], LSB first. Each bit lasts CLK_DIV cycles. After bit_idx=7 completes, go to STOP (or PARITY).
  - STOP: uart_txd=1 for CLK_DIV cycles.
    - On its last cycle, if hold_valid: load the shifter from the holding register, clear hold_valid, go to START. There are no idle cycles between frames.
    - Otherwise go to IDLE.
- Baud counter:
  - Width is clog2(CLK_DIV).
  - Counts 0..CLK_DIV-1; the bit-end strobe fires when baud_cnt == CLK_DIV-1.
  - Counter wraps to 0 on that strobe.
- Frame length is 10*CLK_DIV cycles (11*CLK_DIV with parity), measured from the uart_txd falling edge to the next start or idle.
- Simultaneous events:
  - A request accepted in the same cycle the shifter drains the holding register cannot happen, because acceptance requires hold_valid=0.
  - A request accepted on the last STOP cycle while hold_valid=0 is not loaded that edge. It is loaded on the next edge from IDLE, giving one idle cycle of uart_txd=1.
- uart_tx_active is 1 in every state except IDLE.
- uart_send_data is sampled only at acceptance; later changes do not affect the frame.

Optional Feature:
- Macro: `UART_TX_PARITY_EN`.
- Defined:
  - PARITY state inserted between DATA and STOP, lasting CLK_DIV cycles.
  - uart_txd = XOR of the 8 data bits, XOR PARITY_ODD.
  - Frame is 11*CLK_DIV cycles.
- Undefined:
  - No PARITY state and no parity logic.
  - PARITY_ODD is unused; frame is 10*CLK_DIV.

Test Plan:
- Reset/idle:
  - Stimulus: rst=0 for 3 cycles, then rst=1 for 20 cycles with uart_send=0.
  - Required: uart_txd=1, uart_send_busy=0, uart_tx_active=0 throughout.
- Single byte, CLK_DIV=4:
  - Stimulus: send 8'hA5 at cycle N.
  - Required: busy=1 only at cycle N+1.
  - Required: uart_txd from N+1 for 40 cycles is 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
  - Required: uart_tx_active drops after those 40 cycles.
- Back-to-back, CLK_DIV=4:
  - Stimulus: send 8'h00, then 8'hFF as soon as busy=0.
  - Required: second byte is held (busy=1) until the last stop cycle of the first frame.
  - Required: second start bit immediately follows 4 stop cycles; 80 contiguous cycles with no extra idle.
- Drop while busy, CLK_DIV=4:
  - Stimulus: send 8'h11, 8'h22, and 8'h33 on consecutive busy-gated opportunities; hold uart_send=1 with 8'h44 while busy=1.
  - Required: 8'h44 is never transmitted until busy=0.
  - Required: exactly the accepted bytes appear, in order.
- Reset mid-frame, CLK_DIV=4:
  - Stimulus: assert rst=0 during DATA bit 3 of 8'h00 with a byte pending.
  - Required: uart_txd=1 and busy=0 after that edge.
  - Required: the pending byte is discarded and no frame follows rst release.
- Parity (`UART_TX_PARITY_EN`, PARITY_ODD=0, CLK_DIV=4):
  - Stimulus: send 8'h07.
  - Required: parity bit=1 held 4 cycles before stop; total frame 44 cycles.
  - With PARITY_ODD=1: parity bit=0.
